// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the memory bus arbiter.
//               Contents: owner_e (fetch or data port), arb_state_e
//               (arbiter state names), S_TYPE_W (access size/sign code width)
//               and S_TYPE_WORD (code for a word access).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } arb_state_e;

   localparam int                    S_TYPE_W    = 3;
   localparam logic [S_TYPE_W-1:0]   S_TYPE_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_cnt
// Description : Saturating 8-bit wait-cycle counter with a terminal-count
//               flag used to bound how long a transaction may wait.
// Ports       : clk    - system clock
//               reset  - asynchronous active-high reset
//               clear  - restart counting from zero (new transaction)
//               enable - count this cycle (waiting, no response seen)
//               tc     - current wait cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   // The counter holds the number of wait cycles already completed, so the
   // current cycle is the TIMEOUT_CYC-th one when it equals TIMEOUT_CYC-1.
   localparam logic [7:0] c_TC_VAL  = 8'(TIMEOUT_CYC - 1);
   localparam logic [7:0] c_CNT_MAX = 8'hFF;

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && (r_cnt != c_CNT_MAX)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign tc = (r_cnt == c_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between the instruction-fetch port
//               and the load/store data port. One transaction outstanding,
//               round-robin on conflicts, per-transaction timeout.
// Ports       : clk, reset                         - clock, async reset
//               if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_err
//                                                  - fetch port
//               d_req/d_we/d_s_type/d_addr/d_wdata
//                  -> d_gnt/d_rvalid/d_rdata/d_err - data port
//               m_req/m_we/m_s_type/m_addr/m_wdata <- m_gnt/m_rvalid/m_rdata
//                                                  - memory port
//               stall                              - core hold request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                reset,
   // fetch port
   input  logic                if_req,
   input  logic [31:0]         if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [31:0]         if_rdata,
   output logic                if_err,
   // data port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [S_TYPE_W-1:0] d_s_type,
   input  logic [31:0]         d_addr,
   input  logic [31:0]         d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [31:0]         d_rdata,
   output logic                d_err,
   // memory port
   output logic                m_req,
   output logic                m_we,
   output logic [S_TYPE_W-1:0] m_s_type,
   output logic [31:0]         m_addr,
   output logic [31:0]         m_wdata,
   input  logic                m_gnt,
   input  logic                m_rvalid,
   input  logic [31:0]         m_rdata,
   // core hold
   output logic                stall
);

   localparam logic [1:0] c_ST_IDLE   = IDLE;
   localparam logic [1:0] c_ST_WAIT_I = WAIT_I;
   localparam logic [1:0] c_ST_WAIT_D = WAIT_D;

   logic [1:0] r_state;
   owner_e     r_last_owner;

   logic w_idle;
   logic w_wait_i;
   logic w_wait_d;
   logic w_busy;
   logic w_sel_i;
   logic w_sel_d;
   logic w_accept;
   logic w_tc;
   logic w_done;

   // Forwarding is suppressed while reset is held so every output is quiet
   // even if the core keeps its request lines up during reset.
   assign w_idle   = (r_state == c_ST_IDLE) && !reset;
   assign w_wait_i = (r_state == c_ST_WAIT_I);
   assign w_wait_d = (r_state == c_ST_WAIT_D);
   assign w_busy   = w_wait_i | w_wait_d;

   // Data wins alone, or on a conflict when fetch owned the previous
   // transaction; everything else that requests goes to fetch.
   assign w_sel_d  = w_idle & d_req & (~if_req | (r_last_owner == OWN_I));
   assign w_sel_i  = w_idle & if_req & ~w_sel_d;
   assign w_accept = m_req & m_gnt;

   // A real response takes priority over a timeout landing in the same cycle.
   assign w_done   = w_busy & (m_rvalid | w_tc);

   bus_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (w_accept),
      .enable (w_busy & ~m_rvalid),
      .tc     (w_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_ST_IDLE;
         r_last_owner <= OWN_D;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_state      <= w_sel_d ? c_ST_WAIT_D : c_ST_WAIT_I;
                  r_last_owner <= w_sel_d ? OWN_D : OWN_I;
               end
            end
            c_ST_WAIT_I, c_ST_WAIT_D: begin
               if (w_done) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Request routing to memory (only ever non-zero in IDLE).
   assign m_req = w_sel_i | w_sel_d;

   always_comb begin
      m_we     = 1'b0;
      m_s_type = '0;
      m_addr   = '0;
      m_wdata  = '0;
      if (w_sel_d) begin
         m_we     = d_we;
         m_s_type = d_s_type;
         m_addr   = d_addr;
         m_wdata  = d_wdata;
      end else if (w_sel_i) begin
         m_s_type = S_TYPE_WORD;
         m_addr   = if_addr;
      end
   end

   assign if_gnt = w_sel_i & m_gnt;
   assign d_gnt  = w_sel_d & m_gnt;

   // Responses only exist in a WAIT state; m_rvalid seen in IDLE is dropped.
   assign if_rvalid = w_wait_i & w_done;
   assign if_err    = w_wait_i & ~m_rvalid & w_tc;
   assign if_rdata  = (w_wait_i & m_rvalid) ? m_rdata : 32'h0;

   assign d_rvalid  = w_wait_d & w_done;
   assign d_err     = w_wait_d & ~m_rvalid & w_tc;
   assign d_rdata   = (w_wait_d & m_rvalid) ? m_rdata : 32'h0;

   assign stall = ~reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt) | (w_busy & ~w_done));

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//               followed by randomized traffic against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
   import bus_pkg::*;

   localparam int c_TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [2:0]  d_s_type;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [2:0]  m_s_type;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYC(c_TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_s_type(d_s_type), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_s_type(m_s_type), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .stall(stall)
   );

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] outs();
      return {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
              m_req, m_we, m_s_type, m_addr, m_wdata, stall};
   endfunction

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_s_type = 0; d_addr = 0; d_wdata = 0;
      m_gnt = 0; m_rvalid = 0; m_rdata = 0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- randomized traffic with timeline model ----------------
   bit          mb_busy, mb_last_d, mb_own_d, ip, dp, dwe;
   int          due, mem_at;
   logic [31:0] ia, da, dwd;
   logic [2:0]  dst;

   task automatic run_random(input int n, input int req_pct, input int gnt_pct,
                             input int lmax, input int spur_pct, input bit chk_alt);
      bit          sel_d, sel_i, e_mreq, e_ig, e_dg, resp, err, prev_valid, prev_d;
      logic [31:0] md;
      next_cyc();
      reset = 1; idle_inputs(); #1; reset = 0;
      mb_busy = 0; mb_last_d = 1; mb_own_d = 0; ip = 0; dp = 0;
      due = -1; mem_at = -1; prev_valid = 0; prev_d = 0;
      ia = 0; da = 0; dwd = 0; dst = 0; dwe = 0;
      for (int c = 0; c < n; c++) begin
         next_cyc();
         if (!ip && ($urandom_range(99) < req_pct)) begin
            ip = 1; ia = $urandom;
         end
         if (!dp && ($urandom_range(99) < req_pct)) begin
            dp = 1; dwe = 1'($urandom); dst = 3'($urandom); da = $urandom; dwd = $urandom;
         end
         md = $urandom;
         if_req = ip; if_addr = ia;
         d_req = dp; d_we = dwe; d_s_type = dst; d_addr = da; d_wdata = dwd;
         m_gnt    = ($urandom_range(99) < gnt_pct);
         m_rvalid = mb_busy ? (c == mem_at) : ($urandom_range(99) < spur_pct);
         m_rdata  = md;
         // conflict goes to the port that did not own the previous transaction
         sel_d  = !mb_busy && dp && (!ip || !mb_last_d);
         sel_i  = !mb_busy && ip && !sel_d;
         e_mreq = sel_d || sel_i;
         e_ig   = sel_i && m_gnt;
         e_dg   = sel_d && m_gnt;
         resp   = mb_busy && (c == due);
         err    = resp && (c != mem_at);
         #3;
         check("m_req", m_req, e_mreq);
         check("m_addr", m_addr, sel_d ? da : (sel_i ? ia : 32'h0));
         check("m_ctl", {m_we, m_s_type, m_wdata},
               sel_d ? {dwe, dst, dwd} : (sel_i ? {1'b0, 3'b010, 32'h0} : 36'h0));
         check("gnt", {if_gnt, d_gnt}, {e_ig, e_dg});
         check("rvalid", {if_rvalid, d_rvalid}, {resp && !mb_own_d, resp && mb_own_d});
         if (resp)
            check("resp", mb_own_d ? {d_err, d_rdata} : {if_err, if_rdata},
                  {err, err ? 32'h0 : md});
         check("stall", stall, (ip && !e_ig) || (dp && !e_dg) || (mb_busy && !resp));
         if (chk_alt && (if_gnt || d_gnt)) begin
            if (prev_valid) check("alternate", d_gnt, !prev_d);
            prev_valid = 1;
            prev_d     = d_gnt;
         end
         if (resp) begin
            mb_busy = 0;
         end else if (!mb_busy && e_mreq && m_gnt) begin
            int lat;
            lat       = $urandom_range(lmax, 1);
            mb_busy   = 1;
            mb_own_d  = sel_d;
            mb_last_d = sel_d;
            if (sel_d) dp = 0; else ip = 0;
            mem_at = (lat <= c_TO) ? c + lat : -1;
            due    = c + ((lat <= c_TO) ? lat : c_TO);
         end
      end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      // reset state
      @(posedge clk); #4;
      check("rst_zero", outs(), 160'h0);
      if_req = 1; d_req = 1; m_gnt = 1; #1;
      check("rst_gated", outs(), 160'h0);
      idle_inputs();
      next_cyc();
      reset = 0;

      // single fetch, zero-wait memory
      if_req = 1; if_addr = 32'h10; m_gnt = 1; #3;
      check("if_gnt", {if_gnt, m_req, m_addr, m_s_type, m_we}, {1'b1, 1'b1, 32'h10, 3'b010, 1'b0});
      next_cyc();
      if_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0050_0093; #3;
      check("if_resp", {if_rvalid, if_rdata, if_err, stall}, {1'b1, 32'h0050_0093, 1'b0, 1'b0});
      next_cyc();
      idle_inputs();

      // first conflict after reset goes to fetch
      reset = 1; #1; reset = 0;
      next_cyc();
      if_req = 1; if_addr = 32'h20; d_req = 1; d_addr = 32'h100; d_s_type = 3'b010; m_gnt = 1; #3;
      check("conf_first", {if_gnt, d_gnt, stall}, 3'b101);
      next_cyc();
      if_req = 0; m_rvalid = 1; m_rdata = 32'h1111_2222; #3;
      check("conf_resp", {if_rvalid, d_gnt, stall}, 3'b101);
      next_cyc();
      m_rvalid = 0; #3;
      check("conf_second", {d_gnt, m_addr, m_we}, {1'b1, 32'h100, 1'b0});
      next_cyc();
      d_req = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001; #3;
      check("d_load", {d_rvalid, d_rdata, d_err}, {1'b1, 32'hCAFE_0001, 1'b0});
      next_cyc();
      idle_inputs();

      // store, memory stalls the grant one cycle
      next_cyc();
      d_req = 1; d_we = 1; d_s_type = 3'b000; d_addr = 32'h200; d_wdata = 32'hAB; #3;
      check("st_hold", {d_gnt, m_req, stall}, 3'b011);
      next_cyc();
      m_gnt = 1; #3;
      check("st_acc", {d_gnt, m_we, m_s_type, m_wdata}, {1'b1, 1'b1, 3'b000, 32'hAB});
      next_cyc();
      d_req = 0; m_gnt = 0; #3;
      check("st_wait", {stall, d_rvalid}, 2'b10);
      next_cyc();
      m_rvalid = 1; #3;
      check("st_ack", {d_rvalid, d_err, stall}, 3'b100);
      next_cyc();
      idle_inputs();

      // timeout with a late response afterwards
      next_cyc();
      d_req = 1; d_addr = 32'h300; m_gnt = 1; #3;
      check("to_acc", d_gnt, 1'b1);
      for (int k = 1; k < c_TO; k++) begin
         next_cyc();
         d_req = 0; m_gnt = 0; #3;
         check("to_early", d_rvalid, 1'b0);
      end
      next_cyc(); #3;
      check("to_pulse", {d_rvalid, d_err, d_rdata, stall}, {1'b1, 1'b1, 32'h0, 1'b0});
      next_cyc(); #3;
      check("to_after", d_rvalid, 1'b0);
      next_cyc();
      m_rvalid = 1; m_rdata = 32'h1234; #3;
      check("late_drop", {if_rvalid, d_rvalid}, 2'b00);
      next_cyc();
      idle_inputs();

      // reset in the middle of a data transaction
      next_cyc();
      d_req = 1; d_addr = 32'h400; m_gnt = 1; #3;
      check("mid_acc", d_gnt, 1'b1);
      next_cyc();
      d_req = 0; m_gnt = 0; #1;
      reset = 1; #1;
      check("rst_mid", outs(), 160'h0);
      next_cyc();
      reset = 0; m_rvalid = 1; m_rdata = 32'h5555; #3;
      check("rst_drop", {if_rvalid, d_rvalid, stall}, 3'b000);
      next_cyc();
      m_rvalid = 0; if_req = 1; d_req = 1; m_gnt = 1; #3;
      check("rst_conf", {if_gnt, d_gnt}, 2'b10);
      next_cyc();
      idle_inputs();

      // continuous conflict, zero-wait memory, then general random traffic
      run_random(200, 100, 100, 1, 0, 1'b1);
      run_random(3000, 50, 60, c_TO + 2, 10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
